fu_branch_pipe: RTL and testbench

FU_BRANCH_PIPE -- requirements
Module: fu_branch_pipe

---
 rtl/fu_branch_pipe_if.sv | 46 ++++
 rtl/fu_branch_pipe.sv | 214 +++++++++++++++++++++
 tb/tb_fu_branch_pipe.sv | 439 ++++++++++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/fu_branch_pipe_if.sv
// Issue, result and BTB-update channels of the branch unit.
// The slave modport is the unit's view; master is the surrounding pipeline.
interface fu_branch_pipe_if #(
    parameter int unsigned XLEN = 32,
    parameter int unsigned TAGW = 4
);
    logic            in_valid;
    logic            in_ready;
    logic [3:0]      in_op;
    logic [XLEN-1:0] in_pc;
    logic [XLEN-1:0] in_imm;
    logic [XLEN-1:0] in_rs1;
    logic [XLEN-1:0] in_rs2;
    logic            in_pred_taken;
    logic [TAGW-1:0] in_tag;
    logic            flush;

    logic            res_valid;
    logic            res_taken;
    logic            res_mispredict;
    logic [TAGW-1:0] res_tag;
    logic [XLEN-1:0] res_correct_pc;
    logic [XLEN-1:0] res_link;

    logic            btb_upd_valid;
    logic            btb_upd_ready;
    logic [XLEN-1:0] btb_upd_pc;
    logic [XLEN-1:0] btb_upd_target;
    logic            btb_upd_taken;

    modport master (
        output in_valid, in_op, in_pc, in_imm, in_rs1, in_rs2, in_pred_taken, in_tag, flush,
        output btb_upd_ready,
        input  in_ready,
        input  res_valid, res_taken, res_mispredict, res_tag, res_correct_pc, res_link,
        input  btb_upd_valid, btb_upd_pc, btb_upd_target, btb_upd_taken
    );

    modport slave (
        input  in_valid, in_op, in_pc, in_imm, in_rs1, in_rs2, in_pred_taken, in_tag, flush,
        input  btb_upd_ready,
        output in_ready,
        output res_valid, res_taken, res_mispredict, res_tag, res_correct_pc, res_link,
        output btb_upd_valid, btb_upd_pc, btb_upd_target, btb_upd_taken
    );
endinterface

// File: rtl/fu_branch_pipe.sv
// Two-stage branch resolution unit feeding a BTB-update FIFO.
// Optional feature macro: BRANCH_STATS_EN adds saturating resolve/mispredict counters.
module fu_branch_pipe #(
    parameter int unsigned XLEN       = 32,
    parameter int unsigned TAGW       = 4,
    parameter int unsigned BTBQ_DEPTH = 4
) (
    input logic             CLK,
    input logic             RST,
    fu_branch_pipe_if.slave bif
`ifdef BRANCH_STATS_EN
    ,
    output logic [31:0]     stat_resolved,
    output logic [31:0]     stat_mispred
`endif
);
    localparam int unsigned AW = $clog2(BTBQ_DEPTH);

    localparam logic [3:0] OpBeq  = 4'd0;
    localparam logic [3:0] OpBne  = 4'd1;
    localparam logic [3:0] OpBlt  = 4'd4;
    localparam logic [3:0] OpBge  = 4'd5;
    localparam logic [3:0] OpBltu = 4'd6;
    localparam logic [3:0] OpBgeu = 4'd7;
    localparam logic [3:0] OpJal  = 4'd8;
    localparam logic [3:0] OpJalr = 4'd9;

    // ---------------------------------------------------------------- S1 (operand capture)
    logic            accept;
    logic            s1_valid_q, s1_valid_d;
    logic [3:0]      s1_op_q;
    logic [XLEN-1:0] s1_pc_q, s1_imm_q, s1_rs1_q, s1_rs2_q;
    logic            s1_pred_q;
    logic [TAGW-1:0] s1_tag_q;

    assign accept     = bif.in_valid && bif.in_ready;
    assign s1_valid_d = accept && !bif.flush;

    always_ff @(posedge CLK) begin
        if (RST) begin
            s1_valid_q <= 1'b0;
        end else begin
            s1_valid_q <= s1_valid_d;
        end
    end

    always_ff @(posedge CLK) begin
        if (accept) begin
            s1_op_q   <= bif.in_op;
            s1_pc_q   <= bif.in_pc;
            s1_imm_q  <= bif.in_imm;
            s1_rs1_q  <= bif.in_rs1;
            s1_rs2_q  <= bif.in_rs2;
            s1_pred_q <= bif.in_pred_taken;
            s1_tag_q  <= bif.in_tag;
        end
    end

    // ---------------------------------------------------------------- S1 evaluation
    logic            cmp_eq, cmp_lt, cmp_ltu;
    logic [XLEN-1:0] pc_plus_imm, rs1_plus_imm, pc_plus_4;
    logic            s2_valid_d, s2_taken_d, s2_mispred_d, s2_legal_d;
    logic [XLEN-1:0] s2_target_d, s2_correct_pc_d;

    assign cmp_eq       = (s1_rs1_q == s1_rs2_q);
    assign cmp_lt       = ($signed(s1_rs1_q) < $signed(s1_rs2_q));
    assign cmp_ltu      = (s1_rs1_q < s1_rs2_q);
    assign pc_plus_imm  = s1_pc_q + s1_imm_q;
    assign rs1_plus_imm = s1_rs1_q + s1_imm_q;
    assign pc_plus_4    = s1_pc_q + XLEN'(4);
    assign s2_valid_d   = s1_valid_q && !bif.flush;

    always_comb begin
        s2_taken_d  = 1'b0;
        s2_legal_d  = 1'b1;
        s2_target_d = pc_plus_imm;
        case (s1_op_q)
            OpBeq:   s2_taken_d = cmp_eq;
            OpBne:   s2_taken_d = !cmp_eq;
            OpBlt:   s2_taken_d = cmp_lt;
            OpBge:   s2_taken_d = !cmp_lt;
            OpBltu:  s2_taken_d = cmp_ltu;
            OpBgeu:  s2_taken_d = !cmp_ltu;
            OpJal:   s2_taken_d = 1'b1;
            OpJalr: begin
                s2_taken_d  = 1'b1;
                s2_target_d = {rs1_plus_imm[XLEN-1:1], 1'b0};
            end
            // Illegal codes resolve not-taken and never touch the BTB.
            default: s2_legal_d = 1'b0;
        endcase
        s2_correct_pc_d = s2_taken_d ? s2_target_d : pc_plus_4;
        s2_mispred_d    = (s2_taken_d != s1_pred_q);
    end

    // ---------------------------------------------------------------- S2 (result register)
    logic            s2_valid_q, s2_taken_q, s2_mispred_q, s2_legal_q;
    logic [TAGW-1:0] s2_tag_q;
    logic [XLEN-1:0] s2_correct_pc_q, s2_link_q, s2_pc_q, s2_target_q;

    always_ff @(posedge CLK) begin
        if (RST) begin
            s2_valid_q      <= 1'b0;
            s2_taken_q      <= 1'b0;
            s2_mispred_q    <= 1'b0;
            s2_legal_q      <= 1'b0;
            s2_tag_q        <= '0;
            s2_correct_pc_q <= '0;
            s2_link_q       <= '0;
            s2_pc_q         <= '0;
            s2_target_q     <= '0;
        end else begin
            s2_valid_q <= s2_valid_d;
            if (s2_valid_d) begin
                s2_taken_q      <= s2_taken_d;
                s2_mispred_q    <= s2_mispred_d;
                s2_legal_q      <= s2_legal_d;
                s2_tag_q        <= s1_tag_q;
                s2_correct_pc_q <= s2_correct_pc_d;
                s2_link_q       <= pc_plus_4;
                s2_pc_q         <= s1_pc_q;
                s2_target_q     <= s2_target_d;
            end
        end
    end

    // A flush in the result cycle also suppresses the op sitting in S2.
    assign bif.res_valid      = s2_valid_q && !bif.flush;
    assign bif.res_taken      = s2_taken_q;
    assign bif.res_mispredict = s2_mispred_q;
    assign bif.res_tag        = s2_tag_q;
    assign bif.res_correct_pc = s2_correct_pc_q;
    assign bif.res_link       = s2_link_q;

    // ---------------------------------------------------------------- BTB update FIFO
    logic            q_push, q_pop, q_empty;
    logic [AW-1:0]   wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
    logic [AW:0]     count_q, count_d;
    logic [XLEN-1:0] q_pc_q     [BTBQ_DEPTH];
    logic [XLEN-1:0] q_target_q [BTBQ_DEPTH];
    logic            q_taken_q  [BTBQ_DEPTH];

    assign q_empty = (count_q == '0);
    assign q_push  = bif.res_valid && s2_legal_q;
    assign q_pop   = !q_empty && bif.btb_upd_ready;

    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        if (q_push) wr_ptr_d = wr_ptr_q + AW'(1);
        if (q_pop)  rd_ptr_d = rd_ptr_q + AW'(1);
        count_d = count_q + {{AW{1'b0}}, q_push} - {{AW{1'b0}}, q_pop};
    end

    always_ff @(posedge CLK) begin
        if (RST) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
        end
    end

    always_ff @(posedge CLK) begin
        if (q_push) begin
            q_pc_q[wr_ptr_q]     <= s2_pc_q;
            q_target_q[wr_ptr_q] <= s2_target_q;
            q_taken_q[wr_ptr_q]  <= s2_taken_q;
        end
    end

    assign bif.btb_upd_valid  = !q_empty;
    assign bif.btb_upd_pc     = q_empty ? '0 : q_pc_q[rd_ptr_q];
    assign bif.btb_upd_target = q_empty ? '0 : q_target_q[rd_ptr_q];
    assign bif.btb_upd_taken  = q_empty ? 1'b0 : q_taken_q[rd_ptr_q];

    // ---------------------------------------------------------------- Issue credit
    // Every op in S1/S2 holds a reserved queue slot, so a push can never find the queue full.
    logic [AW+1:0] occupancy;

    assign occupancy    = {1'b0, count_q} + (AW + 2)'(s1_valid_q) + (AW + 2)'(s2_valid_q);
    assign bif.in_ready = !bif.flush && (occupancy < (AW + 2)'(BTBQ_DEPTH));

    // ---------------------------------------------------------------- Optional statistics
`ifdef BRANCH_STATS_EN
    logic [31:0] stat_resolved_q, stat_mispred_q;

    always_ff @(posedge CLK) begin
        if (RST) begin
            stat_resolved_q <= '0;
            stat_mispred_q  <= '0;
        end else begin
            if (bif.res_valid && (stat_resolved_q != '1)) begin
                stat_resolved_q <= stat_resolved_q + 32'd1;
            end
            if (bif.res_valid && s2_mispred_q && (stat_mispred_q != '1)) begin
                stat_mispred_q <= stat_mispred_q + 32'd1;
            end
        end
    end

    assign stat_resolved = stat_resolved_q;
    assign stat_mispred  = stat_mispred_q;
`endif

    // ---------------------------------------------------------------- Invariants
    assert property (@(posedge CLK) disable iff (RST)
        !(q_push && !q_pop && (count_q == (AW + 1)'(BTBQ_DEPTH))));
    assert property (@(posedge CLK) disable iff (RST) occupancy <= (AW + 2)'(BTBQ_DEPTH));

endmodule

// File: tb/tb_fu_branch_pipe.sv
// Self-checking bench for fu_branch_pipe: directed corner cases plus a randomized run
// scored against a cycle-level reference model of results and the BTB-update FIFO.
module tb_fu_branch_pipe;
    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    fu_branch_pipe_if #(.XLEN(32), .TAGW(4)) bif ();

`ifdef BRANCH_STATS_EN
    logic [31:0] stat_resolved, stat_mispred;
`endif

    fu_branch_pipe #(.XLEN(32), .TAGW(4), .BTBQ_DEPTH(4)) dut (
        .CLK (clk),
        .RST (rst),
        .bif (bif)
`ifdef BRANCH_STATS_EN
        ,
        .stat_resolved (stat_resolved),
        .stat_mispred  (stat_mispred)
`endif
    );

    int n_checks = 0;
    int n_pass   = 0;

    typedef struct {
        int          due;
        logic [31:0] pc, target, cpc, link;
        logic        taken, mis, legal;
        logic [3:0]  tag;
    } res_t;

    typedef struct {
        logic [31:0] pc, target;
        logic        taken;
    } btb_t;

    typedef struct {
        logic [3:0]  op;
        logic [31:0] pc, imm, rs1, rs2;
        logic        pred, taken, mis;
        logic [31:0] cpc, link, target;
        logic        btb;
    } dir_t;

    logic [3:0] legal_ops [8] = '{4'd0, 4'd1, 4'd4, 4'd5, 4'd6, 4'd7, 4'd8, 4'd9};

    // Architectural meaning of each branch op, independent of any pipeline detail.
    function automatic res_t ref_eval(input logic [3:0] op, input logic [31:0] pc, imm, rs1, rs2,
                                      input logic pred, input logic [3:0] tag);
        res_t r;
        longint s1, s2;
        s1       = longint'($signed(rs1));
        s2       = longint'($signed(rs2));
        r.due    = 0;
        r.legal  = 1'b1;
        r.taken  = 1'b0;
        r.target = pc + imm;
        case (op)
            4'd0: r.taken = (rs1 == rs2);
            4'd1: r.taken = (rs1 != rs2);
            4'd4: r.taken = (s1 < s2);
            4'd5: r.taken = (s1 >= s2);
            4'd6: r.taken = (rs1 < rs2);
            4'd7: r.taken = (rs1 >= rs2);
            4'd8: r.taken = 1'b1;
            4'd9: begin
                r.taken  = 1'b1;
                r.target = (rs1 + imm) & 32'hFFFF_FFFE;
            end
            default: r.legal = 1'b0;
        endcase
        r.link = pc + 32'd4;
        r.cpc  = r.taken ? r.target : r.link;
        r.mis  = (r.taken != pred);
        r.pc   = pc;
        r.tag  = tag;
        return r;
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic idle();
        bif.in_valid = 1'b0;
        bif.flush    = 1'b0;
    endtask

    task automatic drive_op(input logic [3:0] op, input logic [31:0] pc, imm, rs1, rs2,
                            input logic pred, input logic [3:0] tag);
        bif.in_valid      = 1'b1;
        bif.in_op         = op;
        bif.in_pc         = pc;
        bif.in_imm        = imm;
        bif.in_rs1        = rs1;
        bif.in_rs2        = rs2;
        bif.in_pred_taken = pred;
        bif.in_tag        = tag;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        idle();
        bif.btb_upd_ready = 1'b0;
        drive_op(4'd0, 32'h0, 32'h0, 32'h0, 32'h0, 1'b0, 4'd0);
        bif.in_valid = 1'b0;
        tick();
        tick();
        rst = 1'b0;
        #1;
        n_checks++;
        if (bif.in_ready !== 1'b1) $display("FAIL reset_in_ready got %0b want 1", bif.in_ready);
        else n_pass++;
        n_checks++;
        if ({bif.res_valid, bif.res_taken, bif.res_mispredict, bif.btb_upd_valid,
             bif.btb_upd_taken} !== 5'b0)
            $display("FAIL reset_flags got %b want 00000", {bif.res_valid, bif.res_taken,
                     bif.res_mispredict, bif.btb_upd_valid, bif.btb_upd_taken});
        else n_pass++;
        n_checks++;
        if ({bif.res_correct_pc, bif.res_link, bif.res_tag, bif.btb_upd_pc,
             bif.btb_upd_target} !== '0)
            $display("FAIL reset_data got %h %h %h %h %h want all zero", bif.res_correct_pc,
                     bif.res_link, bif.res_tag, bif.btb_upd_pc, bif.btb_upd_target);
        else n_pass++;
`ifdef BRANCH_STATS_EN
        n_checks++;
        if ({stat_resolved, stat_mispred} !== 64'd0)
            $display("FAIL reset_stats got %0d %0d want 0 0", stat_resolved, stat_mispred);
        else n_pass++;
`endif
    endtask

    task automatic test_directed();
        dir_t dt [6];
        int   nmis = 0;
        dt[0] = '{4'd0, 32'h100, 32'h20, 32'd5, 32'd5, 1'b0, 1'b1, 1'b1, 32'h120, 32'h104,
                  32'h120, 1'b1};
        dt[1] = '{4'd4, 32'h300, 32'h40, 32'hFFFF_FFFF, 32'd1, 1'b1, 1'b1, 1'b0, 32'h340,
                  32'h304, 32'h340, 1'b1};
        dt[2] = '{4'd6, 32'h300, 32'h40, 32'hFFFF_FFFF, 32'd1, 1'b1, 1'b0, 1'b1, 32'h304,
                  32'h304, 32'h340, 1'b1};
        dt[3] = '{4'd9, 32'h200, 32'h4, 32'h1003, 32'd0, 1'b1, 1'b1, 1'b0, 32'h1006, 32'h204,
                  32'h1006, 1'b1};
        dt[4] = '{4'd3, 32'h400, 32'h8, 32'd1, 32'd1, 1'b1, 1'b0, 1'b1, 32'h404, 32'h404,
                  32'h0, 1'b0};
        dt[5] = '{4'd7, 32'hFFFF_FFFC, 32'h8, 32'd3, 32'd3, 1'b0, 1'b1, 1'b1, 32'h4, 32'h0,
                  32'h4, 1'b1};
        for (int i = 0; i < 6; i++) begin
            if (dt[i].mis) nmis++;
            drive_op(dt[i].op, dt[i].pc, dt[i].imm, dt[i].rs1, dt[i].rs2, dt[i].pred, 4'(i));
            #1;
            n_checks++;
            if (bif.in_ready !== 1'b1) $display("FAIL dir%0d_accept in_ready %0b want 1", i,
                                                bif.in_ready);
            else n_pass++;
            tick();
            idle();
            n_checks++;
            if (bif.res_valid !== 1'b0) $display("FAIL dir%0d_early res_valid 1 want 0", i);
            else n_pass++;
            tick();
            n_checks++;
            if ({bif.res_valid, bif.res_taken, bif.res_mispredict, bif.res_tag} !==
                {1'b1, dt[i].taken, dt[i].mis, 4'(i)})
                $display("FAIL dir%0d_flags got v%0b t%0b m%0b tag%0d want v1 t%0b m%0b tag%0d",
                         i, bif.res_valid, bif.res_taken, bif.res_mispredict, bif.res_tag,
                         dt[i].taken, dt[i].mis, i);
            else n_pass++;
            n_checks++;
            if ({bif.res_correct_pc, bif.res_link} !== {dt[i].cpc, dt[i].link})
                $display("FAIL dir%0d_pcs got cpc %h link %h want cpc %h link %h", i,
                         bif.res_correct_pc, bif.res_link, dt[i].cpc, dt[i].link);
            else n_pass++;
            tick();
            n_checks++;
            if ({bif.res_valid, bif.btb_upd_valid} !== {1'b0, dt[i].btb})
                $display("FAIL dir%0d_btbv got res_valid %0b btb_valid %0b want 0 %0b", i,
                         bif.res_valid, bif.btb_upd_valid, dt[i].btb);
            else n_pass++;
            if (dt[i].btb) begin
                n_checks++;
                if ({bif.btb_upd_pc, bif.btb_upd_target, bif.btb_upd_taken} !==
                    {dt[i].pc, dt[i].target, dt[i].taken})
                    $display("FAIL dir%0d_btb got %h %h %0b want %h %h %0b", i, bif.btb_upd_pc,
                             bif.btb_upd_target, bif.btb_upd_taken, dt[i].pc, dt[i].target,
                             dt[i].taken);
                else n_pass++;
            end
            bif.btb_upd_ready = 1'b1;
            tick();
            bif.btb_upd_ready = 1'b0;
            n_checks++;
            if (bif.btb_upd_valid !== 1'b0) $display("FAIL dir%0d_drain btb_valid 1 want 0", i);
            else n_pass++;
        end
`ifdef BRANCH_STATS_EN
        n_checks++;
        if ({stat_resolved, stat_mispred} !== {32'd6, 32'(nmis)})
            $display("FAIL dir_stats got %0d %0d want 6 %0d", stat_resolved, stat_mispred, nmis);
        else n_pass++;
`endif
    endtask

    task automatic test_backpressure();
        int acc = 0;
        bif.btb_upd_ready = 1'b0;
        for (int i = 0; i < 10; i++) begin
            drive_op(4'd8, 32'h1000 + 32'(16 * acc), 32'h10, 32'd0, 32'd0, 1'b1, 4'(i));
            #1;
            if (bif.in_ready) acc++;
            tick();
        end
        #1;
        n_checks++;
        if (acc != 4) $display("FAIL bp_accepted got %0d want 4", acc);
        else n_pass++;
        n_checks++;
        if (bif.in_ready !== 1'b0) $display("FAIL bp_full in_ready 1 want 0");
        else n_pass++;
        n_checks++;
        if ({bif.btb_upd_valid, bif.btb_upd_pc} !== {1'b1, 32'h1000})
            $display("FAIL bp_head0 got v%0b pc %h want v1 pc 00001000", bif.btb_upd_valid,
                     bif.btb_upd_pc);
        else n_pass++;
        bif.in_valid      = 1'b0;
        bif.btb_upd_ready = 1'b1;
        tick();
        bif.btb_upd_ready = 1'b0;
        n_checks++;
        if (bif.in_ready !== 1'b1) $display("FAIL bp_reopen in_ready 0 want 1");
        else n_pass++;
        bif.btb_upd_ready = 1'b1;
        for (int k = 1; k < 4; k++) begin
            n_checks++;
            if ({bif.btb_upd_valid, bif.btb_upd_pc, bif.btb_upd_target, bif.btb_upd_taken} !==
                {1'b1, 32'h1000 + 32'(16 * k), 32'h1010 + 32'(16 * k), 1'b1})
                $display("FAIL bp_order%0d got v%0b %h %h want v1 %h %h", k, bif.btb_upd_valid,
                         bif.btb_upd_pc, bif.btb_upd_target, 32'h1000 + 32'(16 * k),
                         32'h1010 + 32'(16 * k));
            else n_pass++;
            tick();
        end
        bif.btb_upd_ready = 1'b0;
        n_checks++;
        if (bif.btb_upd_valid !== 1'b0) $display("FAIL bp_empty btb_valid 1 want 0");
        else n_pass++;
    endtask

    task automatic test_flush();
        bif.btb_upd_ready = 1'b0;
        drive_op(4'd8, 32'h500, 32'h8, 32'd0, 32'd0, 1'b1, 4'd1);
        tick();
        idle();
        tick();
        tick();
        drive_op(4'd0, 32'h600, 32'h10, 32'd7, 32'd7, 1'b0, 4'd2);
        #1;
        n_checks++;
        if (bif.in_ready !== 1'b1) $display("FAIL fl_accept in_ready 0 want 1");
        else n_pass++;
        tick();
        drive_op(4'd8, 32'h700, 32'h10, 32'd0, 32'd0, 1'b1, 4'd3);
        bif.flush = 1'b1;
        #1;
        n_checks++;
        if (bif.in_ready !== 1'b0) $display("FAIL fl_ready in_ready 1 want 0");
        else n_pass++;
        tick();
        idle();
        for (int i = 0; i < 3; i++) begin
            n_checks++;
            if (bif.res_valid !== 1'b0) $display("FAIL fl_nores%0d res_valid 1 want 0", i);
            else n_pass++;
            tick();
        end
        n_checks++;
        if ({bif.btb_upd_valid, bif.btb_upd_pc} !== {1'b1, 32'h500})
            $display("FAIL fl_kept got v%0b pc %h want v1 pc 00000500", bif.btb_upd_valid,
                     bif.btb_upd_pc);
        else n_pass++;
        bif.btb_upd_ready = 1'b1;
        tick();
        bif.btb_upd_ready = 1'b0;
        n_checks++;
        if (bif.btb_upd_valid !== 1'b0) $display("FAIL fl_noenq btb_valid 1 want 0");
        else n_pass++;
    endtask

    task automatic test_reset_mid();
        bif.btb_upd_ready = 1'b0;
        for (int i = 0; i < 3; i++) begin
            drive_op(4'd8, 32'h800 + 32'(16 * i), 32'h4, 32'd0, 32'd0, 1'b0, 4'(i));
            tick();
        end
        idle();
        tick();
        tick();
        drive_op(4'd1, 32'h900, 32'h4, 32'd1, 32'd2, 1'b0, 4'd9);
        tick();
        n_checks++;
        if (bif.btb_upd_valid !== 1'b1) $display("FAIL rm_queued btb_valid 0 want 1");
        else n_pass++;
        rst       = 1'b1;
        bif.flush = 1'b1;
        drive_op(4'd8, 32'hA00, 32'h4, 32'd0, 32'd0, 1'b0, 4'd10);
        tick();
        rst = 1'b0;
        idle();
        #1;
        n_checks++;
        if ({bif.btb_upd_valid, bif.res_valid, bif.in_ready} !== 3'b001)
            $display("FAIL rm_after got btbv%0b resv%0b rdy%0b want 0 0 1", bif.btb_upd_valid,
                     bif.res_valid, bif.in_ready);
        else n_pass++;
`ifdef BRANCH_STATS_EN
        n_checks++;
        if ({stat_resolved, stat_mispred} !== 64'd0)
            $display("FAIL rm_stats got %0d %0d want 0 0", stat_resolved, stat_mispred);
        else n_pass++;
`endif
        for (int i = 0; i < 3; i++) begin
            tick();
            n_checks++;
            if ({bif.res_valid, bif.btb_upd_valid} !== 2'b00)
                $display("FAIL rm_quiet%0d got resv%0b btbv%0b want 0 0", i, bif.res_valid,
                         bif.btb_upd_valid);
            else n_pass++;
        end
    endtask

    task automatic test_random();
        res_t pend [$];
        btb_t expq [$];
        res_t r;
        int   nres = 0;
        int   nmis = 0;
        int   sel;
        logic exp_ready, exp_rv, exp_bv;
        rst = 1'b1;
        idle();
        bif.btb_upd_ready = 1'b0;
        tick();
        rst = 1'b0;
        for (int c = 0; c < 1500; c++) begin
            sel = int'($urandom_range(0, 9));
            bif.in_valid      = ($urandom_range(0, 9) < 7);
            bif.in_op         = (sel < 8) ? legal_ops[sel] :
                                (sel == 8) ? 4'd3 : 4'($urandom_range(10, 15));
            bif.in_pc         = $urandom;
            bif.in_imm        = $urandom;
            bif.in_rs1        = ($urandom_range(0, 3) == 0) ? 32'($urandom_range(0, 4)) : $urandom;
            bif.in_rs2        = ($urandom_range(0, 3) == 0) ? bif.in_rs1 : $urandom;
            bif.in_pred_taken = ($urandom_range(0, 1) == 1);
            bif.in_tag        = 4'($urandom);
            bif.flush         = ($urandom_range(0, 31) == 0);
            bif.btb_upd_ready = ($urandom_range(0, 1) == 1);
            #1;
            exp_ready = !bif.flush && ((expq.size() + pend.size()) < 4);
            n_checks++;
            if (bif.in_ready !== exp_ready)
                $display("FAIL rnd_ready c%0d got %0b want %0b", c, bif.in_ready, exp_ready);
            else n_pass++;
            exp_rv = !bif.flush && (pend.size() > 0) && (pend[0].due == c);
            n_checks++;
            if (bif.res_valid !== exp_rv)
                $display("FAIL rnd_resv c%0d got %0b want %0b", c, bif.res_valid, exp_rv);
            else n_pass++;
            if (exp_rv) begin
                n_checks++;
                if ({bif.res_taken, bif.res_mispredict, bif.res_tag, bif.res_correct_pc,
                     bif.res_link} !== {pend[0].taken, pend[0].mis, pend[0].tag, pend[0].cpc,
                                         pend[0].link})
                    $display("FAIL rnd_res c%0d got t%0b m%0b tag%0d %h %h want t%0b m%0b tag%0d %h %h",
                             c, bif.res_taken, bif.res_mispredict, bif.res_tag,
                             bif.res_correct_pc, bif.res_link, pend[0].taken, pend[0].mis,
                             pend[0].tag, pend[0].cpc, pend[0].link);
                else n_pass++;
            end
            exp_bv = (expq.size() > 0);
            n_checks++;
            if (bif.btb_upd_valid !== exp_bv)
                $display("FAIL rnd_btbv c%0d got %0b want %0b", c, bif.btb_upd_valid, exp_bv);
            else n_pass++;
            if (exp_bv) begin
                n_checks++;
                if ({bif.btb_upd_pc, bif.btb_upd_target, bif.btb_upd_taken} !==
                    {expq[0].pc, expq[0].target, expq[0].taken})
                    $display("FAIL rnd_btb c%0d got %h %h %0b want %h %h %0b", c,
                             bif.btb_upd_pc, bif.btb_upd_target, bif.btb_upd_taken,
                             expq[0].pc, expq[0].target, expq[0].taken);
                else n_pass++;
                if (bif.btb_upd_ready) void'(expq.pop_front());
            end
            if (bif.flush) begin
                pend.delete();
            end else if ((pend.size() > 0) && (pend[0].due == c)) begin
                r = pend.pop_front();
                nres++;
                if (r.mis) nmis++;
                if (r.legal) expq.push_back('{r.pc, r.target, r.taken});
            end
            if (bif.in_valid && exp_ready) begin
                r = ref_eval(bif.in_op, bif.in_pc, bif.in_imm, bif.in_rs1, bif.in_rs2,
                             bif.in_pred_taken, bif.in_tag);
                r.due = c + 2;
                pend.push_back(r);
            end
            tick();
        end
        idle();
        #1;
`ifdef BRANCH_STATS_EN
        n_checks++;
        if ({stat_resolved, stat_mispred} !== {32'(nres), 32'(nmis)})
            $display("FAIL rnd_stats got %0d %0d want %0d %0d", stat_resolved, stat_mispred,
                     nres, nmis);
        else n_pass++;
`endif
        n_checks++;
        if (nres < 100) $display("FAIL rnd_coverage resolved %0d want >= 100", nres);
        else n_pass++;
    endtask

    initial begin
        test_reset();
        test_directed();
        test_backpressure();
        test_flush();
        test_reset_mid();
        test_random();
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end
endmodule
